caracol_seq_gen: RTL and testbench
==================================

CARACOL_SEQ_GEN -- requirements
Module: caracol_seq_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-003 SHALL have port start, input, 1 bit: request to transmit a burst; sampled only in IDLE.
REQ-004 SHALL have port pattern, input, 4 bits: frame data, sent MSB first (pattern[3] first).
REQ-005 SHALL have port reps, input, 3 bits: frames in burst = reps+1 (range 1..8).
REQ-006 SHALL have port gap_len, input, 3 bits: idle cycles between consecutive frames (0..7).
REQ-007 SHALL have port x, output, 1 bit: serial bit stream; this is the stimulus the caracol Mealy detector consumes.
REQ-008 SHALL have port x_valid, output, 1 bit: x carries a frame bit this cycle.
REQ-009 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-011 SHALL implement the FSM states IDLE, SEND and GAP.
REQ-012 SHALL, in IDLE with start=1, latch pattern, reps and gap_len and enter SEND on the next edge; pattern is sampled on the start cycle only.
REQ-013 SHALL, in SEND, drive x = the current frame bit with x_valid=1, advancing one bit per cycle; a 4-bit frame occupies exactly 4 cycles.
REQ-014 SHALL present the first bit (pattern[3]) in the cycle immediately after the start cycle (latency 1).
REQ-015 SHALL, after the last bit of a frame with frames remaining, enter GAP for gap_len cycles, or re-enter SEND directly (back-to-back frames) when gap_len=0.
REQ-016 SHALL, in GAP, drive x=0 and x_valid=0, then re-enter SEND with the same latched pattern.
REQ-017 SHALL, after the last bit of the final frame, return to IDLE and assert done=1 for the first IDLE cycle only.
REQ-018 SHALL ignore start while busy=1 (no queuing, no restart); start in the done cycle is accepted.
REQ-019 SHALL ignore changes to pattern, reps and gap_len while busy=1.
REQ-020 SHALL hold x=0 and x_valid=0 whenever it is not in SEND.
REQ-021 SHALL use a 3-bit frame counter and a 3-bit gap counter that never wrap: the frame counter ends at reps+1 frames (max 8) and the gap counter at gap_len.

Reset
REQ-022 SHALL, when reset=0 at a rising edge, enter IDLE and clear x, x_valid, busy, done and all counters.
REQ-023 SHALL abort any in-progress burst on reset: no done pulse, and x_valid=0 from the next edge.
REQ-024 SHALL give reset priority over start in the same cycle.

Configuration
REQ-025 SHALL, with macro CARACOL_SEQ_GEN_PARITY_EN defined, append one even-parity bit (XOR of pattern[3:0]) after each frame's data bits; the frame is then 5 SEND cycles with x_valid=1 on all five.
REQ-026 SHALL, without CARACOL_SEQ_GEN_PARITY_EN defined, send 4-bit frames only and contain no parity logic.

Structure
REQ-027 SHALL take the state enum (IDLE/SEND/GAP), DATA_BITS=4, the frame-length constant (4 or 5, depending on the macro) and the counter widths from shared package caracol_pkg.
REQ-028 SHALL place the load/shift of the frame bits in one sub-module, caracol_frame_shifter (load, shift, serial out); the FSM and counters stay in the top module.

Verification
REQ-029 SHALL cover: pattern=1101, reps=0, gap_len=0, start in cycle 0 -> x=1,1,0,1 with x_valid=1 in cycles 1-4; done=1 and busy=0 in cycle 5.
REQ-030 SHALL cover: x looped into the caracol Mealy detector; pattern=1101, then 1110 -> detector y=1 on the 4th bit of each frame; pattern=1001 -> y stays 0.
REQ-031 SHALL cover: pattern=1110, reps=2, gap_len=3 -> three frames, each followed by 3 cycles of x_valid=0 except the last; done in cycle 1+4*3+3*2=19.
REQ-032 SHALL cover: reps=1, gap_len=0 -> 8 consecutive x_valid cycles, x=1110 1110; start pulsed mid-burst is ignored.
REQ-033 SHALL cover: reset=0 asserted in cycle 2 of a frame -> x_valid=0 and busy=0 from the next edge, with no done pulse.
REQ-034 SHALL cover, with CARACOL_SEQ_GEN_PARITY_EN defined: pattern=1101 -> x=1,1,0,1,1 over 5 cycles; pattern=1001 -> parity bit 0.

Source files
------------

// File: rtl/caracol_pkg.sv
// Shared types and sizing for the caracol serial sequence generator.
// Macro CARACOL_SEQ_GEN_PARITY_EN appends one even-parity bit to every frame.
package caracol_pkg;

  localparam int unsigned DATA_BITS = 4;
`ifdef CARACOL_SEQ_GEN_PARITY_EN
  localparam int unsigned FRAME_LEN = DATA_BITS + 1;
`else
  localparam int unsigned FRAME_LEN = DATA_BITS;
`endif
  localparam int unsigned FRAME_CNT_W = 3;
  localparam int unsigned GAP_CNT_W   = 3;
  localparam int unsigned BIT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/caracol_frame_shifter.sv
// Holds the latched pattern and the frame shift register; exposes the bit that
// will be on the line after the coming edge. Parity bit under CARACOL_SEQ_GEN_PARITY_EN.
module caracol_frame_shifter
  import caracol_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 reload_i,
  input  logic                 shift_i,
  input  logic [DATA_BITS-1:0] pattern_i,
  output logic                 next_bit_c
);

  logic [DATA_BITS-1:0] pat_q, pat_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;

  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_BITS-1:0] d);
`ifdef CARACOL_SEQ_GEN_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // load takes a fresh pattern; reload restarts the frame from the latched copy
  always_comb begin
    pat_d = pat_q;
    sr_d  = sr_q;
    if (load_i) begin
      pat_d = pattern_i;
      sr_d  = build_frame(pattern_i);
    end else if (reload_i) begin
      sr_d = build_frame(pat_q);
    end else if (shift_i) begin
      sr_d = {sr_q[FRAME_LEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q <= '0;
      sr_q  <= '0;
    end else begin
      pat_q <= pat_d;
      sr_q  <= sr_d;
    end
  end

  assign next_bit_c = sr_d[FRAME_LEN-1];

endmodule

// File: rtl/caracol_seq_gen.sv
// Burst generator: sends reps+1 copies of a 4-bit pattern MSB first, separated
// by gap_len idle cycles. Build with CARACOL_SEQ_GEN_PARITY_EN for 5-bit frames.
module caracol_seq_gen
  import caracol_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_BITS-1:0]   pattern,
  input  logic [FRAME_CNT_W-1:0] reps,
  input  logic [GAP_CNT_W-1:0]   gap_len,
  output logic                   x,
  output logic                   x_valid,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [FRAME_CNT_W-1:0] reps_q, reps_d;
  logic [GAP_CNT_W-1:0]   gap_len_q, gap_len_d;
  logic                   x_q, x_d;
  logic                   x_valid_q, x_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   load, reload, shift;
  logic                   next_bit_c;

  caracol_frame_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .reload_i   (reload),
    .shift_i    (shift),
    .pattern_i  (pattern),
    .next_bit_c (next_bit_c)
  );

  // Next state, counters and the registered line outputs for the coming cycle
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    reps_d      = reps_q;
    gap_len_d   = gap_len_q;
    load        = 1'b0;
    reload      = 1'b0;
    shift       = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load        = 1'b1;
          reps_d      = reps;
          gap_len_d   = gap_len;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          gap_cnt_d   = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bit_cnt_q == BIT_CNT_W'(FRAME_LEN - 1)) begin
          bit_cnt_d = '0;
          if (frame_cnt_q == reps_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            if (gap_len_q == '0) begin
              reload = 1'b1;
            end else begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end
        end else begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == gap_len_q - GAP_CNT_W'(1)) begin
          reload  = 1'b1;
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    x_valid_d = (state_d == SEND);
    x_d       = (state_d == SEND) & next_bit_c;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
      reps_q      <= '0;
      gap_len_q   <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      reps_q      <= reps_d;
      gap_len_q   <= gap_len_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_caracol_seq_gen.sv
// Self-checking bench for caracol_seq_gen: expected line activity is built per
// burst as a list of cycles from the frame/gap rules and compared cycle by cycle.
module tb_caracol_seq_gen;

`ifdef CARACOL_SEQ_GEN_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [2:0] reps;
  logic [2:0] gap_len;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // detector model fed by the DUT stream: fires on 1101 or 1110
  logic [3:0] det_win;
  int         det_hits;
  bit         det_hit4;

  always #5 clk = ~clk;

  caracol_seq_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .gap_len (gap_len),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a burst in the current cycle (DUT must be idle) and checks every cycle
  // up to and including the done cycle; returns while still in the done cycle.
  task automatic run_burst(input logic [3:0] pat, input logic [2:0] r,
                           input logic [2:0] g, input bit noisy);
    logic exp_x[$];
    logic exp_v[$];
    int   vpos;
    logic par;
    par = logic'($countones(pat) % 2);
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_x.push_back(pat[b]);
        exp_v.push_back(1'b1);
      end
      if (FL == 5) begin
        exp_x.push_back(par);
        exp_v.push_back(1'b1);
      end
      if (f < int'(r)) begin
        for (int k = 0; k < int'(g); k++) begin
          exp_x.push_back(1'b0);
          exp_v.push_back(1'b0);
        end
      end
    end
    start   = 1'b1;
    pattern = pat;
    reps    = r;
    gap_len = g;
    det_win = 4'b0000;
    det_hits = 0;
    det_hit4 = 1'b0;
    vpos    = 0;
    for (int i = 0; i < exp_x.size(); i++) begin
      step();
      start = 1'b0;
      if (noisy) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 4'($urandom);
        reps    = 3'($urandom);
        gap_len = 3'($urandom);
      end
      checks++;
      if (x_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL burst_x_valid cyc=%0d got=%b exp=%b", i + 1, x_valid, exp_v[i]);
      end
      checks++;
      if (x !== exp_x[i]) begin
        failures++;
        $display("FAIL burst_x cyc=%0d got=%b exp=%b", i + 1, x, exp_x[i]);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL burst_busy_done cyc=%0d got busy=%b done=%b exp busy=1 done=0",
                 i + 1, busy, done);
      end
      if (x_valid === 1'b1) begin
        det_win = {det_win[2:0], x};
        if (det_win == 4'b1101 || det_win == 4'b1110) begin
          det_hits++;
          if (vpos == 3) det_hit4 = 1'b1;
        end
        vpos++;
      end
    end
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0 || x !== 1'b0) begin
      failures++;
      $display("FAIL burst_done cyc=%0d got done=%b busy=%b xv=%b x=%b exp 1 0 0 0",
               exp_x.size() + 1, done, busy, x_valid, x);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || x_valid !== 1'b0 || x !== 1'b0) begin
      failures++;
      $display("FAIL %s got done=%b busy=%b xv=%b x=%b exp all 0", name, done, busy, x_valid, x);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    pattern = 4'hF;
    reps = 3'd7;
    gap_len = 3'd7;
    step();
    step();
    check_idle("reset_state");
    reset = 1'b1;
    start = 1'b0;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_single();
    run_burst(4'b1101, 3'd0, 3'd0, 1'b0);
    step();
    check_idle("single_after_done");
  endtask

  task automatic test_detector();
    logic [3:0] pats [3];
    bit         hit  [3];
    pats[0] = 4'b1101; hit[0] = 1'b1;
    pats[1] = 4'b1110; hit[1] = 1'b1;
    pats[2] = 4'b1001; hit[2] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      run_burst(pats[p], 3'd0, 3'd0, 1'b0);
      checks++;
      if (det_hit4 !== hit[p]) begin
        failures++;
        $display("FAIL detector_4th_bit pat=%b got=%b exp=%b", pats[p], det_hit4, hit[p]);
      end
      if (!hit[p]) begin
        checks++;
        if (det_hits != 0) begin
          failures++;
          $display("FAIL detector_silent pat=%b got hits=%0d exp 0", pats[p], det_hits);
        end
      end
      step();
    end
  endtask

  task automatic test_gaps();
    run_burst(4'b1110, 3'd2, 3'd3, 1'b1);
    step();
    check_idle("gaps_after_done");
  endtask

  task automatic test_back_to_back();
    run_burst(4'b1110, 3'd1, 3'd0, 1'b1);
    run_burst(4'($urandom), 3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 1'b1);
    step();
    check_idle("b2b_after_done");
  endtask

  task automatic test_abort();
    start = 1'b1;
    pattern = 4'b1101;
    reps = 3'd3;
    gap_len = 3'd1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (x_valid !== 1'b1 || x !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got xv=%b x=%b exp 1 1", x_valid, x);
    end
    reset = 1'b0;
    step();
    check_idle("abort_next_edge");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle("abort_no_done");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_burst(4'($urandom), 3'($urandom), 3'($urandom), 1'b1);
      step();
      check_idle("random_after_done");
    end
  endtask

`ifdef CARACOL_SEQ_GEN_PARITY_EN
  task automatic test_parity();
    run_burst(4'b1101, 3'd0, 3'd0, 1'b0);
    step();
    run_burst(4'b1001, 3'd1, 3'd2, 1'b0);
    step();
    check_idle("parity_after_done");
  endtask
`endif

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pattern = 4'h0;
    reps = 3'd0;
    gap_len = 3'd0;
    test_reset();
    test_single();
    test_detector();
    test_gaps();
    test_back_to_back();
    test_abort();
    test_random();
`ifdef CARACOL_SEQ_GEN_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
